// File: rtl/tpu_pkg.sv
// Shared types and elaboration helpers for the systolic-array tile scheduler.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    function automatic int unsigned tile_num(input int unsigned col_num,
                                             input int unsigned pe_size);
        return col_num / pe_size;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/tpu_phase_counter.sv
// Up-counter with clear and enable; saturates at last_i and flags it.
module tpu_phase_counter
    import tpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != last_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Layer-pass sequencer: per tile an ifmap preload then a stallable weight
// stream, followed by a fixed drain and a one-cycle done pulse.
module tpu_tile_scheduler
    import tpu_pkg::*;
#(
    parameter  int unsigned PE_SIZE        = 14,
    parameter  int unsigned WEIGHT_ROW_NUM = 70,
    parameter  int unsigned WEIGHT_COL_NUM = 294,
    parameter  int unsigned DRAIN_LAT      = 28,
    localparam int unsigned TILE_NUM       = tile_num(WEIGHT_COL_NUM, PE_SIZE),
    localparam int unsigned ADDR_W         = clog2(WEIGHT_COL_NUM),
    localparam int unsigned ROW_W          = clog2(WEIGHT_ROW_NUM),
    localparam int unsigned TILE_W         = clog2(TILE_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              ofmap_full_i,
    output logic              acc_rst_o,
    output logic              ifmap_rd_en_o,
    output logic [ADDR_W-1:0] ifmap_addr_o,
    output logic              weight_rd_en_o,
    output logic [ROW_W-1:0]  weight_addr_o,
    output logic              psum_en_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = clog2(max3(PE_SIZE, WEIGHT_ROW_NUM, DRAIN_LAT));

    if (WEIGHT_COL_NUM % PE_SIZE != 0) begin : g_bad_cfg
        $fatal(1, "WEIGHT_COL_NUM must be a multiple of PE_SIZE");
    end

    state_e            state_q, state_d;
    logic              acc_rst_q, acc_rst_d;
    logic              ifmap_rd_en_q, ifmap_rd_en_d;
    logic [ADDR_W-1:0] ifmap_addr_q, ifmap_addr_d;
    logic              weight_rd_en_q, weight_rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              phase_clr, phase_en, phase_tc;
    logic [CNT_W-1:0]  phase_last, phase_cnt;
    logic              tile_clr, tile_en, tile_tc;
    logic [TILE_W-1:0] tile_cnt;

    tpu_phase_counter #(.WIDTH(CNT_W)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (phase_clr),
        .en_i   (phase_en),
        .last_i (phase_last),
        .cnt_o  (phase_cnt),
        .tc_o   (phase_tc)
    );

    tpu_phase_counter #(.WIDTH(TILE_W)) u_tile_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tile_clr),
        .en_i   (tile_en),
        .last_i (TILE_W'(TILE_NUM - 1)),
        .cnt_o  (tile_cnt),
        .tc_o   (tile_tc)
    );

    always_comb begin
        case (state_q)
            PRELOAD: phase_last = CNT_W'(PE_SIZE - 1);
            STREAM:  phase_last = CNT_W'(WEIGHT_ROW_NUM - 1);
            default: phase_last = CNT_W'(DRAIN_LAT - 1);
        endcase
    end

    always_comb begin
        state_d        = state_q;
        acc_rst_d      = 1'b0;
        ifmap_rd_en_d  = 1'b0;
        ifmap_addr_d   = ifmap_addr_q;
        weight_rd_en_d = 1'b0;
        done_d         = 1'b0;
        phase_clr      = 1'b0;
        phase_en       = 1'b0;
        tile_clr       = 1'b0;
        tile_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = PRELOAD;
                    acc_rst_d     = 1'b1;
                    ifmap_rd_en_d = 1'b1;
                    ifmap_addr_d  = '0;
                    phase_clr     = 1'b1;
                    tile_clr      = 1'b1;
                end
            end
            PRELOAD: begin
                // Address runs continuously across tiles, so it lands on the next tile base.
                if (ifmap_addr_q != ADDR_W'(WEIGHT_COL_NUM - 1)) begin
                    ifmap_addr_d = ifmap_addr_q + 1'b1;
                end
                if (phase_tc) begin
                    state_d        = STREAM;
                    phase_clr      = 1'b1;
                    weight_rd_en_d = 1'b1;
                end else begin
                    phase_en      = 1'b1;
                    ifmap_rd_en_d = 1'b1;
                end
            end
            STREAM: begin
                // Row advances only after a cycle that actually issued; stalls hold it.
                if (weight_rd_en_q && phase_tc) begin
                    phase_clr = 1'b1;
                    if (tile_tc) begin
                        state_d = DRAIN;
                    end else begin
                        state_d       = PRELOAD;
                        tile_en       = 1'b1;
                        ifmap_rd_en_d = 1'b1;
                    end
                end else begin
                    phase_en       = weight_rd_en_q;
                    weight_rd_en_d = !ofmap_full_i;
                end
            end
            DRAIN: begin
                if (phase_tc) begin
                    state_d   = DONE;
                    phase_clr = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    phase_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i) begin
            state_d        = IDLE;
            acc_rst_d      = 1'b0;
            ifmap_rd_en_d  = 1'b0;
            ifmap_addr_d   = '0;
            weight_rd_en_d = 1'b0;
            done_d         = 1'b0;
            phase_clr      = 1'b1;
            phase_en       = 1'b0;
            tile_clr       = 1'b1;
            tile_en        = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_rst_q      <= 1'b0;
            ifmap_rd_en_q  <= 1'b0;
            ifmap_addr_q   <= '0;
            weight_rd_en_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_rst_q      <= acc_rst_d;
            ifmap_rd_en_q  <= ifmap_rd_en_d;
            ifmap_addr_q   <= ifmap_addr_d;
            weight_rd_en_q <= weight_rd_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign acc_rst_o      = acc_rst_q;
    assign ifmap_rd_en_o  = ifmap_rd_en_q;
    assign ifmap_addr_o   = ifmap_addr_q;
    assign weight_rd_en_o = weight_rd_en_q;
    assign psum_en_o      = weight_rd_en_q;
    assign weight_addr_o  = phase_cnt[ROW_W-1:0];
    assign tile_idx_o     = tile_cnt;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed self-checking bench for tpu_tile_scheduler at default parameters.
module tb_tpu_tile_scheduler;

    localparam int PE    = 14;
    localparam int ROWS  = 70;
    localparam int TILES = 21;
    localparam int DRAIN = 28;
    localparam int PASS_LEN = 1793;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       ofmap_full_i = 1'b0;
    logic       acc_rst_o, ifmap_rd_en_o, weight_rd_en_o, psum_en_o, busy_o, done_o;
    logic [8:0] ifmap_addr_o;
    logic [6:0] weight_addr_o;
    logic [4:0] tile_idx_o;

    int total = 0;
    int bad   = 0;

    tpu_tile_scheduler #(
        .PE_SIZE        (14),
        .WEIGHT_ROW_NUM (70),
        .WEIGHT_COL_NUM (294),
        .DRAIN_LAT      (28)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .ofmap_full_i   (ofmap_full_i),
        .acc_rst_o      (acc_rst_o),
        .ifmap_rd_en_o  (ifmap_rd_en_o),
        .ifmap_addr_o   (ifmap_addr_o),
        .weight_rd_en_o (weight_rd_en_o),
        .weight_addr_o  (weight_addr_o),
        .psum_en_o      (psum_en_o),
        .tile_idx_o     (tile_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Full cycle-accurate walk through one pass; stall_tile < 0 disables the stall.
    task automatic run_pass(input int stall_tile, input int stall_row,
                            input int stall_len, input logic full_quiet, input string name);
        int r;
        int srem;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int t = 0; t < TILES; t++) begin
            for (int p = 0; p < PE; p++) begin
                check($sformatf("%s pre t%0d p%0d", name, t, p),
                      32'({ifmap_rd_en_o, ifmap_addr_o, weight_rd_en_o, psum_en_o,
                           tile_idx_o, busy_o, done_o, acc_rst_o}),
                      32'({1'b1, 9'(t * PE + p), 1'b0, 1'b0,
                           5'(t), 1'b1, 1'b0, (t == 0 && p == 0)}));
                ofmap_full_i = full_quiet;
                step();
            end
            r = 0;
            srem = 0;
            while (r < ROWS) begin
                check($sformatf("%s str t%0d r%0d", name, t, r),
                      32'({ifmap_rd_en_o, weight_rd_en_o, psum_en_o, weight_addr_o,
                           tile_idx_o, busy_o, done_o, acc_rst_o}),
                      32'({1'b0, (srem == 0), (srem == 0), 7'(r),
                           5'(t), 1'b1, 1'b0, 1'b0}));
                if (srem > 0) begin
                    srem--;
                end else begin
                    if (t == stall_tile && r == stall_row - 1) srem = stall_len;
                    r++;
                end
                ofmap_full_i = (srem > 0) ? 1'b1 : ((r == ROWS) ? full_quiet : 1'b0);
                step();
            end
        end
        for (int d = 0; d < DRAIN; d++) begin
            check($sformatf("%s drain d%0d", name, d),
                  32'({ifmap_rd_en_o, weight_rd_en_o, psum_en_o, tile_idx_o, busy_o, done_o}),
                  32'({1'b0, 1'b0, 1'b0, 5'd20, 1'b1, 1'b0}));
            ofmap_full_i = full_quiet;
            step();
        end
        check({name, " done"},
              32'({busy_o, done_o, ifmap_rd_en_o, weight_rd_en_o}),
              32'({1'b1, 1'b1, 1'b0, 1'b0}));
        ofmap_full_i = 1'b0;
        step();
        check({name, " idle"}, 32'({busy_o, done_o, acc_rst_o}), 32'd0);
    endtask

    // Called in the first PRELOAD cycle; counts cycles up to and including done_o.
    task automatic wait_done(input string name);
        int   n;
        logic acc_seen;
        n = 1;
        acc_seen = 1'b0;
        while (done_o !== 1'b1 && n < 3000) begin
            step();
            n++;
            if (acc_rst_o === 1'b1 && done_o !== 1'b1) acc_seen = 1'b1;
        end
        check({name, " done seen"}, 32'(done_o), 32'd1);
        check({name, " pass length"}, 32'(n), 32'(PASS_LEN));
        check({name, " no acc_rst mid-pass"}, 32'(acc_seen), 32'd0);
    endtask

    initial begin
        logic done_seen;

        repeat (3) step();
        rst = 1'b0;
        check("reset outputs",
              32'({acc_rst_o, ifmap_rd_en_o, ifmap_addr_o, weight_rd_en_o, weight_addr_o,
                   psum_en_o, tile_idx_o, busy_o, done_o}), 32'd0);
        step();
        check("idle after reset", 32'({busy_o, ifmap_rd_en_o, acc_rst_o}), 32'd0);

        run_pass(-1, 0, 0, 1'b0, "plain");
        run_pass(3, 40, 5, 1'b0, "stall");
        run_pass(-1, 0, 0, 1'b1, "fullquiet");

        // Abort in STREAM of tile 10, row 5 (cycle 10*84+14+5 of the pass).
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (859) step();
        check("abort pre", 32'({tile_idx_o, weight_rd_en_o, weight_addr_o, busy_o}),
              32'({5'd10, 1'b1, 7'd5, 1'b1}));
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort next",
              32'({busy_o, ifmap_rd_en_o, weight_rd_en_o, psum_en_o, done_o}), 32'd0);
        done_seen = 1'b0;
        repeat (40) begin
            step();
            if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen = 1'b1;
        end
        check("abort stays idle", 32'(done_seen), 32'd0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("restart",
              32'({acc_rst_o, ifmap_rd_en_o, ifmap_addr_o, tile_idx_o, busy_o}),
              32'({1'b1, 1'b1, 9'd0, 5'd0, 1'b1}));
        wait_done("restart");
        step();

        // Synchronous reset while draining.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (1764 + 10) step();
        check("drain pre-rst",
              32'({busy_o, weight_rd_en_o, ifmap_rd_en_o, done_o, tile_idx_o}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 5'd20}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst in drain",
              32'({acc_rst_o, ifmap_rd_en_o, ifmap_addr_o, weight_rd_en_o, weight_addr_o,
                   psum_en_o, tile_idx_o, busy_o, done_o}), 32'd0);
        step();

        // start held high across a whole pass.
        start_i = 1'b1;
        step();
        wait_done("held");
        step();
        check("held idle gap", 32'({busy_o, acc_rst_o, done_o}), 32'd0);
        step();
        check("held restart",
              32'({busy_o, acc_rst_o, ifmap_rd_en_o, ifmap_addr_o, tile_idx_o}),
              32'({1'b1, 1'b1, 1'b1, 9'd0, 5'd0}));
        start_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("final abort", 32'({busy_o, ifmap_rd_en_o}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
